// File: rtl/wb_pkg.sv
// Purpose: shared Wishbone bus widths and slave FSM state encoding.
// Latency: none, declarations only.
// Backpressure: none, declarations only.
package wb_pkg;

  localparam int WB_DW    = 32;
  localparam int WB_SEL_W = 4;
  localparam int WB_AW    = 32;

  // IDLE samples requests, ACCESS counts wait states and fires the RAM,
  // ACK/ERR are single-cycle terminations.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_ACK    = 2'd2,
    ST_ERR    = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_sram_array.sv
// Purpose: single-port word RAM with per-byte write enables, contents not reset.
// Latency: read data registered, valid the cycle after en_i with we_i = 0.
// Backpressure: none, accepts an access every cycle en_i is high.
module wb_sram_array
  import wb_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [WB_SEL_W-1:0]   sel_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [WB_DW-1:0]      wdata_i,
  output logic [WB_DW-1:0]      rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WB_DW-1:0] mem_q [DEPTH];
  logic [WB_DW-1:0] rdata_q;

  // Byte-lane writes; a write never updates the read register.
  always_ff @(posedge clk) begin
    if (en_i && we_i) begin
      for (int b = 0; b < WB_SEL_W; b++) begin
        if (sel_i[b]) begin
          mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
        end
      end
    end
  end

  // Synchronous full-word read.
  always_ff @(posedge clk) begin
    if (en_i && !we_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram_slave.sv
// Purpose: Wishbone classic single-transfer slave in front of an on-chip word RAM.
// Latency: ACK WAIT_STATES+2 cycles after the sampling edge, ERR 1 cycle after.
// Backpressure: one request at a time; requests are only sampled in IDLE.
module wb_sram_slave
  import wb_pkg::*;
#(
  parameter int          ADDR_WIDTH  = 12,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wb_cyc_i,
  input  logic                wb_stb_i,
  input  logic                wb_we_i,
  input  logic [WB_SEL_W-1:0] wb_sel_i,
  input  logic [WB_AW-1:0]    wb_addr_i,
  input  logic [WB_DW-1:0]    wb_data_i,
  output logic [WB_DW-1:0]    wb_data_o,
  output logic                wb_ack_o,
  output logic                wb_err_o
);

  localparam int          TAG_LSB = ADDR_WIDTH + 2;
  localparam logic [3:0]  WS_CNT  = 4'(WAIT_STATES);

  wb_state_e             state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [WB_SEL_W-1:0]   sel_q, sel_d;
  logic [WB_DW-1:0]      wdat_q, wdat_d;

  logic                  req;
  logic                  in_range;
  logic                  ram_fire;
  logic                  ram_en;
  logic [WB_DW-1:0]      ram_rdata;

  // Byte-offset bits carry no meaning for a word RAM.
  logic                  unused_addr_lsb;
  assign unused_addr_lsb = ^wb_addr_i[1:0];

  assign req      = wb_cyc_i && wb_stb_i;
  assign in_range = (wb_addr_i[WB_AW-1:TAG_LSB] == BASE_ADDR[WB_AW-1:TAG_LSB]);

  // State, wait counter and request latches; reset drops any pending access.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      wdat_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      sel_q   <= sel_d;
      wdat_q  <= wdat_d;
    end
  end

  // Next-state logic: latch in IDLE, count down in ACCESS, fire RAM on the last ACCESS cycle.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    we_d     = we_q;
    sel_d    = sel_q;
    wdat_d   = wdat_q;
    ram_fire = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req) begin
          addr_d = wb_addr_i[TAG_LSB-1:2];
          we_d   = wb_we_i;
          sel_d  = wb_sel_i;
          wdat_d = wb_data_i;
          if (in_range) begin
            state_d = ST_ACCESS;
            cnt_d   = WS_CNT;
          end else begin
            state_d = ST_ERR;
          end
        end
      end
      ST_ACCESS: begin
        if (!wb_cyc_i) begin
          state_d = ST_IDLE;
        end else if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ram_fire = 1'b1;
          state_d  = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // ram_fire already implies cyc; a reset on the final ACCESS cycle must not commit.
  assign ram_en = ram_fire && !rst;

  wb_sram_array #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_array (
    .clk     (clk),
    .en_i    (ram_en),
    .we_i    (we_q),
    .sel_i   (sel_q),
    .addr_i  (addr_q),
    .wdata_i (wdat_q),
    .rdata_o (ram_rdata)
  );

  // Terminations decode straight from state, so they can never overlap.
  assign wb_ack_o  = (state_q == ST_ACK);
  assign wb_err_o  = (state_q == ST_ERR);
  assign wb_data_o = (wb_ack_o && !we_q) ? ram_rdata : '0;

endmodule
